// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the 7-segment HEX bank controller.
// Segment codes are active-low {g..a}.
package hex_disp_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] DIGIT_SEGS [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Largest value representable on n decimal digits.
   function automatic longint unsigned max_display(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p - 1;
   endfunction

endpackage

// File: rtl/hex_digit_seg.sv
// One digit of segment decode: dash beats blank beats numeric code.
// Non-decimal codes render as blank.
module hex_digit_seg
   import hex_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (dash)
         seg = SEG_DASH;
      else if (blank)
         seg = SEG_BLANK;
      else if (digit <= 4'd9)
         seg = DIGIT_SEGS[digit];
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Binary to BCD (shift-add-3, one bit per cycle) driving the HEX bank.
// Segments and overflow are committed together on the FORMAT edge.
module hex_display_ctrl
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BIN_W      = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_W-1:0]        in_value,
   input  logic                    blank_en,
   output logic                    busy,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] hex_segs
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] MAX_VAL =
      BIN_W'(max_display(NUM_DIGITS));

   state_t                    state;
   logic [BIN_W-1:0]          shift_q;
   logic [BCD_W-1:0]          bcd_q;
   logic [BCD_W-1:0]          bcd_adj;
   logic [CNT_W-1:0]          cnt_q;
   logic                      ovf_q;
   logic                      blank_q;
   logic                      nz;
   logic [NUM_DIGITS-1:0]     dig_blank;
   logic [7*NUM_DIGITS-1:0]   seg_w;

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   // Blank every digit above the most significant nonzero one.
   always_comb begin
      nz        = 1'b0;
      dig_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz           = nz | (bcd_q[4*i +: 4] != 4'd0);
         dig_blank[i] = blank_q & ~nz & (i != 0);
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      hex_digit_seg u_seg (
         .digit (bcd_q[4*g +: 4]),
         .blank (dig_blank[g]),
         .dash  (ovf_q),
         .seg   (seg_w[7*g +: 7])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shift_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         blank_q  <= 1'b0;
         overflow <= 1'b0;
         hex_segs <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_q <= in_value;
                  bcd_q   <= '0;
                  cnt_q   <= CNT_W'(BIN_W);
                  ovf_q   <= (in_value > MAX_VAL);
                  blank_q <= blank_en;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1))
                  state <= FORMAT;
            end
            FORMAT: begin
               hex_segs <= seg_w;
               overflow <= ovf_q;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl against a decimal-arithmetic model.
// Directed cases pin known segment patterns and latency.
module tb_hex_display_ctrl;

   localparam int ND = 6;
   localparam int BW = 20;
   localparam int MAXV = 999999;
   localparam logic [6:0] PAT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_value;
   logic          blank_en;
   logic          busy;
   logic          overflow;
   logic [41:0]   hex_segs;

   int n_asserts = 0;
   int n_fails   = 0;

   hex_display_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .blank_en (blank_en),
      .busy     (busy),
      .overflow (overflow),
      .hex_segs (hex_segs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [41:0] fmt(input int v, input bit b);
      logic [41:0] r;
      int p;
      r = '0;
      if (v > MAXV) return {6{7'h3F}};
      p = 1;
      for (int i = 0; i < ND; i++) begin
         if (b && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
         else r[7*i +: 7] = PAT[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: value in, decimal digits out after BW+1 edges.
   logic        m_ready;
   int          m_cnt;
   logic [41:0] m_segs, m_pend_segs;
   logic        m_ovf, m_pend_ovf;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ready <= 1'b1;
         m_cnt   <= 0;
         m_segs  <= {6{7'h7F}};
         m_ovf   <= 1'b0;
      end else if (m_ready && in_valid) begin
         m_ready     <= 1'b0;
         m_cnt       <= BW + 1;
         m_pend_segs <= fmt(int'(in_value), blank_en);
         m_pend_ovf  <= (int'(in_value) > MAXV);
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_segs  <= m_pend_segs;
            m_ovf   <= m_pend_ovf;
            m_ready <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("in_ready", 64'(in_ready), 64'(m_ready));
         chk("busy", 64'(busy), 64'(!m_ready));
         chk("hex_segs", 64'(hex_segs), 64'(m_segs));
         chk("overflow", 64'(overflow), 64'(m_ovf));
      end
   end

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic xfer(input int v, input bit b, input bit hold);
      int n;
      in_valid = 1'b1;
      in_value = BW'(v);
      blank_en = b;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("xfer_timeout", 64'(n), 64'(0));
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit chk_lat);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (chk_lat) chk("busy_cycles", 64'(n), 64'(BW + 1));
   endtask

   task automatic run(input int v, input bit b, input logic [41:0] exp,
                      input bit exp_ovf);
      xfer(v, b, 1'b0);
      wait_done(1'b1);
      chk("lit_segs", 64'(hex_segs), 64'(exp));
      chk("lit_ovf", 64'(overflow), 64'(exp_ovf));
   endtask

   initial begin
      int v, gap;
      bit b, hold;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      blank_en = 1'b0;
      #1;
      chk("rst_segs", 64'(hex_segs), 64'(42'h3FFFFFFFFFF));
      chk("rst_ovf", 64'(overflow), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(1));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run(123456, 1'b0,
          {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0);
      run(42, 1'b1,
          {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0);
      run(42, 1'b0,
          {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 1'b0);
      run(0, 1'b1,
          {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
      run(1000000, 1'b0, {6{7'h3F}}, 1'b1);
      run(999999, 1'b1, {6{7'h10}}, 1'b0);

      // Held valid: 5 then 7 presented back-to-back.
      xfer(5, 1'b0, 1'b1);
      xfer(7, 1'b0, 1'b0);
      wait_done(1'b1);
      chk("b2b_segs", 64'(hex_segs),
          64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}));

      // Reset in the middle of converting 999999.
      xfer(999999, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_segs", 64'(hex_segs), 64'(42'h3FFFFFFFFFF));
      chk("mid_rst_ovf", 64'(overflow), 64'(0));
      chk("mid_rst_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run(7, 1'b0,
          {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 1'b0);

      for (int k = 0; k < 40; k++) begin
         case ($urandom % 4)
            0: v = $urandom_range(0, 99);
            1: v = $urandom_range(999990, 1048575);
            default: v = $urandom_range(0, MAXV);
         endcase
         b    = 1'($urandom % 2);
         hold = 1'($urandom % 2);
         xfer(v, b, hold);
         if (!hold) begin
            gap = $urandom_range(0, 25);
            repeat (gap) @(negedge clk);
         end
      end
      in_valid = 1'b0;
      wait_done(1'b0);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fails);
      $finish;
   end

endmodule
